mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the five-stage RV32I core: it is the consumer of the EXE-stage pipeline register outputs. It issues load/store requests to the data memory over a req/ack handshake, stalls the pipeline while an access is outstanding, aligns and extends load data, and provides the MEM-stage forwarding value. It also holds the MEM/WB pipeline register.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- EXE_pc_to_reg  in  32  PC+4 or PC+imm from EXE.
- EXE_ALU_out  in  32  ALU result; byte address for memory ops.
- EXE_rs2_data  in  32  store data.
- EXE_rd_addr  in  5  destination register.
- EXE_funct3  in  3  access size and sign.
- EXE_RDSrc  in  1  1: pc_to_reg, 0: ALU_out.
- EXE_MemtoReg  in  1  writeback selects load data.
- EXE_MemRead, EXE_MemWrite, EXE_RegWrite  in  1 each  control.
- DM_req  out  1  registered request; held until ack.
- DM_we  out  1  1 = store.
- DM_addr  out  32  byte address.
- DM_be  out  4  byte enables, active-high.
- DM_wdata  out  32  lane-replicated store data.
- DM_rdata  in  32  read data; valid when DM_ack=1.
- DM_ack  in  1  one-cycle completion pulse.
- mem_stall  out  1  upstream stages and EXE registers hold while 1.
- MEM_rd_data  out  32  forwarding value: EXE_RDSrc ? EXE_pc_to_reg : EXE_ALU_out (combinational).
- WB_rd_data, WB_rd_addr, WB_RegWrite  out  32/5/1  MEM/WB register.
- WB_misalign  out  1  registered misalignment flag.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: if MemRead|MemWrite, mem_stall=1 (comb); next=REQ; at the edge, register DM_req=1, DM_we=MemWrite, DM_addr, DM_be, DM_wdata. Otherwise mem_stall=0 and IDLE is held.
- REQ: DM_req=1, mem_stall=1. On DM_ack=1, capture DM_rdata into load_buf; next=DONE, and DM_req clears at that edge.
- DONE: mem_stall=0; the WB register loads at the end of the cycle; next=IDLE. The next instruction enters together with this edge, so there is no re-issue.
- If MemRead and MemWrite are both 1, the access is a store.
- Store enables: funct3 000 gives SB, be=0001<<addr[1:0]. 001 gives SH, be=0011<<{addr[1],0}. 010 gives SW, be=1111. Other funct3 values act as SW.
- Store data: wdata = byte replicated ×4 for SB, half replicated ×2 for SH, rs2 for SW.
- Loads: lane selected by addr[1:0] for bytes and addr[1] for halves. 000 LB and 001 LH sign-extend. 100 LBU and 101 LHU zero-extend. 010 and others act as LW.
- WB_rd_data = EXE_MemtoReg ? extended load_buf : MEM_rd_data.
- WB_rd_addr and WB_RegWrite come from the EXE_* inputs.
- WB register: holds while mem_stall=1; updates every cycle otherwise.
- DM_ack outside REQ is ignored.

## Timing
- Reset: all outputs 0, state IDLE, load_buf 0. Reset takes effect immediately, mid-access included: DM_req drops asynchronously. A late DM_ack after reset is ignored.
- Non-memory instruction: WB register is valid 1 cycle after entry; zero stall.
- Memory op whose ack arrives k cycles after DM_req rises (k≥1):
  - mem_stall is high for k+1 cycles: the entry cycle plus the REQ cycles up to and including the ack cycle.
  - DONE follows.
  - WB is valid at the edge ending DONE.
  - Minimum latency is 3 cycles from entry to WB valid.
- DM_addr, DM_be, DM_wdata, DM_we are stable throughout REQ.
- Back-to-back memory ops: the second op is seen in IDLE the cycle after DONE.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned accesses are LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠0.
  - A misaligned access issues no request and causes no stall.
  - For that instruction: WB_RegWrite=0 and WB_misalign=1 for one cycle.
- MEM_MISALIGN_TRAP_EN undefined:
  - WB_misalign is tied 0.
  - Misaligned accesses are issued using the lane rules above; low address bits are ignored for word accesses.

## Test plan
- Reset mid-REQ with DM_req=1 → DM_req=0 immediately, all WB outputs 0. Ack 2 cycles later → no state change.
- SB rs2=0x000000A5, addr=0x102 → DM_be=0100, DM_wdata=0xA5A5A5A5, DM_we=1. Stall lasts 2 cycles with ack in the first REQ cycle; WB_RegWrite follows the input.
- LB addr=0x103, DM_rdata=0x80FF7F01, ack after 3 cycles → mem_stall high 4 cycles, WB_rd_data=0xFFFFFF80. Repeated as LBU → 0x00000080.
- LH addr=0x202, DM_rdata=0x8001FFFF → WB_rd_data=0xFFFF8001. Repeated as LW addr=0x200 → 0x8001FFFF.
- ALU op with RDSrc=1, pc_to_reg=0x1004 → MEM_rd_data=0x1004 same cycle, WB_rd_data=0x1004 next cycle, no stall. Back-to-back LW, LW → two separate requests, no duplicate.
- With MEM_MISALIGN_TRAP_EN: SW addr=0x101 → no DM_req, mem_stall=0, WB_misalign=1 for one cycle, WB_RegWrite=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
   logic        DM_req;
   logic        DM_we;
   logic [31:0] DM_addr;
   logic [3:0]  DM_be;
   logic [31:0] DM_wdata;
   logic [31:0] DM_rdata;
   logic        DM_ack;

   modport master (
      output DM_req, DM_we, DM_addr, DM_be, DM_wdata,
      input  DM_rdata, DM_ack
   );

   modport slave (
      input  DM_req, DM_we, DM_addr, DM_be, DM_wdata,
      output DM_rdata, DM_ack
   );
endinterface

// File: rtl/mem_stage.sv
// RV32I MEM stage: data-memory req/ack sequencing, load align/extend, forwarding and MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] EXE_pc_to_reg,
   input  logic [31:0] EXE_ALU_out,
   input  logic [31:0] EXE_rs2_data,
   input  logic [4:0]  EXE_rd_addr,
   input  logic [2:0]  EXE_funct3,
   input  logic        EXE_RDSrc,
   input  logic        EXE_MemtoReg,
   input  logic        EXE_MemRead,
   input  logic        EXE_MemWrite,
   input  logic        EXE_RegWrite,
   mem_stage_if.master dm,
   output logic        mem_stall,
   output logic [31:0] MEM_rd_data,
   output logic [31:0] WB_rd_data,
   output logic [4:0]  WB_rd_addr,
   output logic        WB_RegWrite,
   output logic        WB_misalign
);
   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   state_e      state_q, state_d;
   logic [31:0] load_buf_q;
   logic        mem_op, is_byte, is_half, misalign, issue, issue_req;
   logic [1:0]  lane;
   logic [3:0]  be;
   logic [31:0] wdata, ld_ext;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign lane        = EXE_ALU_out[1:0];
   assign mem_op      = EXE_MemRead | EXE_MemWrite;
   assign MEM_rd_data = EXE_RDSrc ? EXE_pc_to_reg : EXE_ALU_out;

   // A store wins when both controls are set; only loads have unsigned size encodings.
   always_comb begin
      is_byte = 1'b0;
      is_half = 1'b0;
      if (EXE_MemWrite) begin
         is_byte = (EXE_funct3 == 3'b000);
         is_half = (EXE_funct3 == 3'b001);
      end else begin
         is_byte = (EXE_funct3 == 3'b000) || (EXE_funct3 == 3'b100);
         is_half = (EXE_funct3 == 3'b001) || (EXE_funct3 == 3'b101);
      end
   end

   always_comb begin
      be    = 4'b1111;
      wdata = EXE_rs2_data;
      if (is_byte) begin
         be    = 4'b0001 << lane;
         wdata = {4{EXE_rs2_data[7:0]}};
      end else if (is_half) begin
         be    = 4'b0011 << {lane[1], 1'b0};
         wdata = {2{EXE_rs2_data[15:0]}};
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign = mem_op & ((is_half & lane[0]) | (~is_byte & ~is_half & (lane != 2'b00)));
`else
   assign misalign = 1'b0;
`endif
   assign issue = mem_op & ~misalign;

   always_comb begin
      state_d   = state_q;
      mem_stall = 1'b0;
      issue_req = 1'b0;
      case (state_q)
         StIdle: begin
            if (issue) begin
               mem_stall = 1'b1;
               issue_req = 1'b1;
               state_d   = StReq;
            end
         end
         StReq: begin
            mem_stall = 1'b1;
            if (dm.DM_ack) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         load_buf_q  <= '0;
         dm.DM_req   <= 1'b0;
         dm.DM_we    <= 1'b0;
         dm.DM_addr  <= '0;
         dm.DM_be    <= '0;
         dm.DM_wdata <= '0;
      end else begin
         state_q <= state_d;
         if (issue_req) begin
            dm.DM_req   <= 1'b1;
            dm.DM_we    <= EXE_MemWrite;
            dm.DM_addr  <= EXE_ALU_out;
            dm.DM_be    <= be;
            dm.DM_wdata <= wdata;
         end else if (state_q == StReq && dm.DM_ack) begin
            dm.DM_req  <= 1'b0;
            load_buf_q <= dm.DM_rdata;
         end
      end
   end

   // EXE inputs still hold the load during DONE, so lane and funct3 are valid here.
   assign ld_byte = load_buf_q[{lane, 3'b000} +: 8];
   assign ld_half = lane[1] ? load_buf_q[31:16] : load_buf_q[15:0];

   always_comb begin
      case (EXE_funct3)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'b0, ld_byte};
         3'b101:  ld_ext = {16'b0, ld_half};
         default: ld_ext = load_buf_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         WB_rd_data  <= '0;
         WB_rd_addr  <= '0;
         WB_RegWrite <= 1'b0;
      end else if (!mem_stall) begin
         WB_rd_data  <= EXE_MemtoReg ? ld_ext : MEM_rd_data;
         WB_rd_addr  <= EXE_rd_addr;
         WB_RegWrite <= EXE_RegWrite & ~misalign;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic misalign_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             misalign_q <= 1'b0;
      else if (!mem_stall) misalign_q <= misalign;
   end
   assign WB_misalign = misalign_q;
`else
   assign WB_misalign = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: drives one instruction at a time and acts as the data memory.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] EXE_pc_to_reg = '0, EXE_ALU_out = '0, EXE_rs2_data = '0;
   logic [4:0]  EXE_rd_addr = '0;
   logic [2:0]  EXE_funct3 = '0;
   logic        EXE_RDSrc = 0, EXE_MemtoReg = 0, EXE_MemRead = 0, EXE_MemWrite = 0;
   logic        EXE_RegWrite = 0;
   logic        mem_stall, WB_RegWrite, WB_misalign;
   logic [31:0] MEM_rd_data, WB_rd_data;
   logic [4:0]  WB_rd_addr;

   mem_stage_if dm ();

   mem_stage u_dut (
      .clk           (clk),
      .rst           (rst),
      .EXE_pc_to_reg (EXE_pc_to_reg),
      .EXE_ALU_out   (EXE_ALU_out),
      .EXE_rs2_data  (EXE_rs2_data),
      .EXE_rd_addr   (EXE_rd_addr),
      .EXE_funct3    (EXE_funct3),
      .EXE_RDSrc     (EXE_RDSrc),
      .EXE_MemtoReg  (EXE_MemtoReg),
      .EXE_MemRead   (EXE_MemRead),
      .EXE_MemWrite  (EXE_MemWrite),
      .EXE_RegWrite  (EXE_RegWrite),
      .dm            (dm),
      .mem_stall     (mem_stall),
      .MEM_rd_data   (MEM_rd_data),
      .WB_rd_data    (WB_rd_data),
      .WB_rd_addr    (WB_rd_addr),
      .WB_RegWrite   (WB_RegWrite),
      .WB_misalign   (WB_misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        rw;
      logic        mis;
   } wb_t;

   wb_t sb_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one instruction at a negedge, answer its request after ack_k REQ cycles,
   // then compare the WB register once the stage stops stalling.
   task automatic exec(input string tag, input logic rd_en, input logic wr_en, input logic rw,
                       input logic m2r, input logic rsrc, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc,
                       input logic [4:0] rd, input int ack_k, input logic [31:0] rdata,
                       input logic [31:0] exp_data, input logic exp_rw, input logic exp_mis,
                       input int exp_stall, input int exp_reqs, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata);
      wb_t  e, got;
      int   stalls, reqs, req_cyc;
      logic prev_req, seen_free;
      EXE_MemRead = rd_en;   EXE_MemWrite = wr_en; EXE_RegWrite = rw;
      EXE_MemtoReg = m2r;    EXE_RDSrc = rsrc;     EXE_funct3 = f3;
      EXE_ALU_out = alu;     EXE_rs2_data = rs2;   EXE_pc_to_reg = pc;
      EXE_rd_addr = rd;
      e.data = exp_data; e.addr = rd; e.rw = exp_rw; e.mis = exp_mis;
      sb_q.push_back(e);
      stalls = 0; reqs = 0; req_cyc = 0; prev_req = 1'b0; seen_free = 1'b0;
      for (int c = 0; c < 40 && !seen_free; c++) begin
         #1;
         if (c == 0) begin
            check_eq({tag, "_fwd"}, MEM_rd_data, rsrc ? pc : alu);
            check_eq({tag, "_req_at_entry"}, {31'b0, dm.DM_req}, 0);
         end
         if (mem_stall) stalls++;
         else begin
            seen_free = 1'b1;
            check_eq({tag, "_req_when_free"}, {31'b0, dm.DM_req}, 0);
         end
         if (dm.DM_req) begin
            if (!prev_req) reqs++;
            req_cyc++;
            check_eq({tag, "_addr"}, dm.DM_addr, alu);
            check_eq({tag, "_we"}, {31'b0, dm.DM_we}, {31'b0, wr_en});
            if (wr_en) begin
               check_eq({tag, "_be"}, {28'b0, dm.DM_be}, {28'b0, exp_be});
               check_eq({tag, "_wdata"}, dm.DM_wdata, exp_wdata);
            end
            if (req_cyc == ack_k) begin
               dm.DM_ack   = 1'b1;
               dm.DM_rdata = rdata;
            end
         end
         prev_req = dm.DM_req;
         @(posedge clk);
         #1;
         dm.DM_ack   = 1'b0;
         dm.DM_rdata = '0;
         @(negedge clk);
      end
      if (!seen_free) check_eq({tag, "_timeout"}, 0, 1);
      check_eq({tag, "_stall_cycles"}, stalls, exp_stall);
      check_eq({tag, "_req_count"}, reqs, exp_reqs);
      if (sb_q.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 0, 1);
      end else begin
         got = sb_q.pop_front();
         check_eq({tag, "_wb_data"}, WB_rd_data, got.data);
         check_eq({tag, "_wb_addr"}, {27'b0, WB_rd_addr}, {27'b0, got.addr});
         check_eq({tag, "_wb_rw"}, {31'b0, WB_RegWrite}, {31'b0, got.rw});
         check_eq({tag, "_wb_mis"}, {31'b0, WB_misalign}, {31'b0, got.mis});
      end
   endtask

   initial begin
      dm.DM_ack   = 1'b0;
      dm.DM_rdata = '0;
      #1 rst = 1'b1;
      #1;
      check_eq("rst_req", {31'b0, dm.DM_req}, 0);
      check_eq("rst_we", {31'b0, dm.DM_we}, 0);
      check_eq("rst_addr", dm.DM_addr, 0);
      check_eq("rst_be", {28'b0, dm.DM_be}, 0);
      check_eq("rst_wdata", dm.DM_wdata, 0);
      check_eq("rst_wb_data", WB_rd_data, 0);
      check_eq("rst_wb_rw", {31'b0, WB_RegWrite}, 0);
      check_eq("rst_stall", {31'b0, mem_stall}, 0);
      @(negedge clk);
      rst = 1'b0;

      //   tag      rd wr rw m2r rsrc f3      alu       rs2           pc       rd k rdata
      //   exp_data  rw mis stall reqs be  wdata
      exec("alu", 0, 0, 1, 0, 1, 3'b000, 32'h55, 32'h0, 32'h1004, 5'd3, 1, 32'h0,
           32'h1004, 1, 0, 0, 0, 4'h0, 32'h0);
      exec("sb", 0, 1, 0, 0, 0, 3'b000, 32'h102, 32'hA5, 32'h0, 5'd0, 1, 32'h0,
           32'h102, 0, 0, 2, 1, 4'b0100, 32'hA5A5A5A5);
      exec("sh", 0, 1, 0, 0, 0, 3'b001, 32'h106, 32'h1234ABCD, 32'h0, 5'd0, 1, 32'h0,
           32'h106, 0, 0, 2, 1, 4'b1100, 32'hABCDABCD);
      exec("sw", 1, 1, 0, 0, 0, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0, 5'd0, 2, 32'h0,
           32'h10C, 0, 0, 3, 1, 4'b1111, 32'hCAFEF00D);
      exec("lb", 1, 0, 1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h0, 5'd5, 3, 32'h80FF7F01,
           32'hFFFFFF80, 1, 0, 4, 1, 4'h0, 32'h0);
      exec("lbu", 1, 0, 1, 1, 0, 3'b100, 32'h103, 32'h0, 32'h0, 5'd6, 3, 32'h80FF7F01,
           32'h00000080, 1, 0, 4, 1, 4'h0, 32'h0);
      exec("lh", 1, 0, 1, 1, 0, 3'b001, 32'h202, 32'h0, 32'h0, 5'd7, 2, 32'h8001FFFF,
           32'hFFFF8001, 1, 0, 3, 1, 4'h0, 32'h0);
      exec("lhu", 1, 0, 1, 1, 0, 3'b101, 32'h202, 32'h0, 32'h0, 5'd8, 1, 32'h8001FFFF,
           32'h00008001, 1, 0, 2, 1, 4'h0, 32'h0);
      exec("lw", 1, 0, 1, 1, 0, 3'b010, 32'h200, 32'h0, 32'h0, 5'd9, 2, 32'h8001FFFF,
           32'h8001FFFF, 1, 0, 3, 1, 4'h0, 32'h0);
      exec("lw_b2b0", 1, 0, 1, 1, 0, 3'b010, 32'h204, 32'h0, 32'h0, 5'd10, 1, 32'h11223344,
           32'h11223344, 1, 0, 2, 1, 4'h0, 32'h0);
      exec("lw_b2b1", 1, 0, 1, 1, 0, 3'b010, 32'h208, 32'h0, 32'h0, 5'd11, 2, 32'h55667788,
           32'h55667788, 1, 0, 3, 1, 4'h0, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
      exec("sw_mis", 0, 1, 0, 0, 0, 3'b010, 32'h101, 32'hDEADBEEF, 32'h0, 5'd0, 1, 32'h0,
           32'h101, 0, 1, 0, 0, 4'h0, 32'h0);
      exec("nop_after_mis", 0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1, 32'h0,
           32'h0, 0, 0, 0, 0, 4'h0, 32'h0);
      exec("lh_mis", 1, 0, 1, 0, 0, 3'b001, 32'h201, 32'h0, 32'h0, 5'd12, 1, 32'h0,
           32'h201, 0, 1, 0, 0, 4'h0, 32'h0);
`else
      exec("sw_unal", 0, 1, 0, 0, 0, 3'b010, 32'h101, 32'hDEADBEEF, 32'h0, 5'd0, 1, 32'h0,
           32'h101, 0, 0, 2, 1, 4'b1111, 32'hDEADBEEF);
`endif
      exec("alu_fill", 0, 0, 1, 0, 0, 3'b000, 32'h77, 32'h0, 32'h0, 5'd4, 1, 32'h0,
           32'h77, 1, 0, 0, 0, 4'h0, 32'h0);

      // Reset in the middle of an outstanding load, then a stray ack.
      EXE_MemRead = 1'b1; EXE_MemWrite = 1'b0; EXE_RegWrite = 1'b1; EXE_MemtoReg = 1'b1;
      EXE_RDSrc = 1'b0; EXE_funct3 = 3'b010; EXE_ALU_out = 32'h300; EXE_rd_addr = 5'd7;
      @(posedge clk);
      #1;
      check_eq("mid_req_up", {31'b0, dm.DM_req}, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("mid_rst_req", {31'b0, dm.DM_req}, 0);
      check_eq("mid_rst_wb_data", WB_rd_data, 0);
      check_eq("mid_rst_wb_addr", {27'b0, WB_rd_addr}, 0);
      check_eq("mid_rst_wb_rw", {31'b0, WB_RegWrite}, 0);
      @(negedge clk);
      EXE_MemRead = 1'b0; EXE_RegWrite = 1'b0; EXE_MemtoReg = 1'b0;
      EXE_ALU_out = '0; EXE_rd_addr = '0; EXE_funct3 = '0;
      rst = 1'b0;
      @(negedge clk);
      dm.DM_ack   = 1'b1;
      dm.DM_rdata = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      dm.DM_ack = 1'b0;
      check_eq("late_ack_req", {31'b0, dm.DM_req}, 0);
      check_eq("late_ack_stall", {31'b0, mem_stall}, 0);
      check_eq("late_ack_wb_data", WB_rd_data, 0);
      check_eq("late_ack_wb_rw", {31'b0, WB_RegWrite}, 0);
      check_eq("sb_drained", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
